// File: rtl/mem_access_unit_pkg.sv
// Shared opcodes, size encodings, FSM state codes and opcode decode for the MEM-stage LSU.
package mem_access_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef struct packed {
    logic       is_mem;
    logic       is_load;
    logic [1:0] size;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [5:0] op);
    op_info_t info;
    info = '0;
    case (op)
      OP_LB, OP_LBU: info = '{is_mem: 1'b1, is_load: 1'b1, size: SZ_BYTE};
      OP_LH, OP_LHU: info = '{is_mem: 1'b1, is_load: 1'b1, size: SZ_HALF};
      OP_LW:         info = '{is_mem: 1'b1, is_load: 1'b1, size: SZ_WORD};
      OP_SB:         info = '{is_mem: 1'b1, is_load: 1'b0, size: SZ_BYTE};
      OP_SH:         info = '{is_mem: 1'b1, is_load: 1'b0, size: SZ_HALF};
      OP_SW:         info = '{is_mem: 1'b1, is_load: 1'b0, size: SZ_WORD};
      default:       info = '0;
    endcase
    return info;
  endfunction

  function automatic logic is_signed_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: request size/strobe/data and alignment faults on the way
// out, lane extraction with sign/zero extension on the way back.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [5:0]                   req_op,
  input  logic [$clog2(DATA_W/8)-1:0]  req_off,
  input  logic [31:0]                  req_wdata,
  output logic                         req_legal,
  output logic                         req_adel,
  output logic                         req_ades,
  output logic                         req_wr,
  output logic [1:0]                   req_size,
  output logic [DATA_W/8-1:0]          req_wstrb,
  output logic [DATA_W-1:0]            req_wdata_rep,
  input  logic [5:0]                   rsp_op,
  input  logic [$clog2(DATA_W/8)-1:0]  rsp_off,
  input  logic [DATA_W-1:0]            rsp_rdata,
  output logic [31:0]                  rsp_data
);
  localparam int unsigned Lanes = DATA_W / 8;

  op_info_t          ri, pi;
  logic              misaligned;
  logic [Lanes-1:0]  base_strb;
  logic [31:0]       lane_word;
  logic              sgn;

  assign ri = decode_op(req_op);
  assign pi = decode_op(rsp_op);

  always_comb begin
    misaligned    = 1'b0;
    base_strb     = Lanes'(4'hF);
    req_wdata_rep = {(Lanes / 4){req_wdata}};
    case (ri.size)
      SZ_BYTE: begin
        base_strb     = Lanes'(1);
        req_wdata_rep = {Lanes{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        misaligned    = req_off[0];
        base_strb     = Lanes'(2'b11);
        req_wdata_rep = {(Lanes / 2){req_wdata[15:0]}};
      end
      default: misaligned = |req_off[1:0];
    endcase
  end

  assign req_legal = ri.is_mem & ~misaligned;
  assign req_adel  = ri.is_mem & ri.is_load & misaligned;
  assign req_ades  = ri.is_mem & ~ri.is_load & misaligned;
  assign req_wr    = ri.is_mem & ~ri.is_load;
  assign req_size  = ri.size;
  assign req_wstrb = req_wr ? (base_strb << req_off) : '0;

  // Bring the addressed byte down to bit 0; the bus word already holds it in its lane.
  assign lane_word = 32'(rsp_rdata >> {rsp_off, 3'b000});
  assign sgn       = is_signed_load(rsp_op);

  always_comb begin
    rsp_data = '0;
    if (pi.is_mem && pi.is_load) begin
      case (pi.size)
        SZ_BYTE: rsp_data = {{24{sgn & lane_word[7]}}, lane_word[7:0]};
        SZ_HALF: rsp_data = {{16{sgn & lane_word[15]}}, lane_word[15:0]};
        default: rsp_data = lane_word;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one sram-like request per access, pipeline stall while the
// handshake is outstanding, discard of results for accesses flushed in flight.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mem_en,
  input  logic [5:0]           op,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [31:0]          wdata,
  input  logic                 flush,
  input  logic                 stall_i,
  output logic                 stall_o,
  output logic [31:0]          rdata_o,
  output logic                 done_o,
  output logic                 adel,
  output logic                 ades,
  output logic [ADDR_W-1:0]    badvaddr,
  output logic                 data_req,
  output logic                 data_wr,
  output logic [1:0]           data_size,
  output logic [ADDR_W-1:0]    data_addr,
  output logic [DATA_W/8-1:0]  data_wstrb,
  output logic [DATA_W-1:0]    data_wdata,
  input  logic                 data_addr_ok,
  input  logic [DATA_W-1:0]    data_rdata,
  input  logic                 data_data_ok
);
  localparam int unsigned Lanes = DATA_W / 8;
  localparam int unsigned LaneW = $clog2(Lanes);

  logic [1:0]        state_q, state_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [Lanes-1:0]  wstrb_q;
  logic [DATA_W-1:0] wdata_q;
  logic [5:0]        op_q;
  logic              wr_q;
  logic [31:0]       rdata_q;

  logic              al_legal, al_adel, al_ades, al_wr;
  logic [1:0]        al_size;
  logic [Lanes-1:0]  al_wstrb;
  logic [DATA_W-1:0] al_wdata;
  logic [31:0]       al_rdata;

  logic              is_idle, start, accept_rsp;

  mem_lane_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .req_op        (op),
    .req_off       (addr[LaneW-1:0]),
    .req_wdata     (wdata),
    .req_legal     (al_legal),
    .req_adel      (al_adel),
    .req_ades      (al_ades),
    .req_wr        (al_wr),
    .req_size      (al_size),
    .req_wstrb     (al_wstrb),
    .req_wdata_rep (al_wdata),
    .rsp_op        (op_q),
    .rsp_off       (addr_q[LaneW-1:0]),
    .rsp_rdata     (data_rdata),
    .rsp_data      (al_rdata)
  );

  assign is_idle    = (state_q == S_IDLE);
  assign start      = is_idle & mem_en & al_legal & ~flush;
  // A flush arriving together with data_ok still cancels the result.
  assign accept_rsp = (state_q == S_WAIT) & data_data_ok & ~discard_q & ~flush;

  assign adel     = is_idle & mem_en & al_adel;
  assign ades     = is_idle & mem_en & al_ades;
  assign badvaddr = (adel | ades) ? addr : '0;

  assign stall_o    = start | (state_q == S_REQ) | (state_q == S_WAIT);
  assign done_o     = (state_q == S_DONE);
  assign rdata_o    = rdata_q;
  assign data_req   = (state_q == S_REQ);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wstrb = wstrb_q;
  assign data_wdata = wdata_q;

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    unique case (state_q)
      S_IDLE: begin
        discard_d = 1'b0;
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        if (flush) discard_d = 1'b1;
        if (data_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok) begin
          state_d   = (discard_q | flush) ? S_IDLE : S_DONE;
          discard_d = 1'b0;
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      S_DONE: begin
        if (flush || !stall_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      op_q      <= '0;
      wr_q      <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (start) begin
        addr_q  <= addr;
        size_q  <= al_size;
        wstrb_q <= al_wstrb;
        wdata_q <= al_wdata;
        op_q    <= op;
        wr_q    <= al_wr;
      end
      if (accept_rsp) rdata_q <= al_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised scoreboard bench for mem_access_unit: 32-bit instance with a bus responder,
// plus a 64-bit instance driven directly for wide-lane steering.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        mem_en, flush, stall_i;
  logic [5:0]  op;
  logic [31:0] addr, wdata;
  logic        stall_o, done_o, adel, ades;
  logic [31:0] rdata_o, badvaddr;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;

  logic        w_mem_en, w_flush, w_stall_i;
  logic [5:0]  w_op;
  logic [31:0] w_addr, w_wdata;
  logic        w_stall_o, w_done, w_adel, w_ades;
  logic [31:0] w_rdata_o, w_badvaddr;
  logic        w_data_req, w_data_wr, w_addr_ok, w_data_ok;
  logic [1:0]  w_data_size;
  logic [31:0] w_data_addr;
  logic [7:0]  w_data_wstrb;
  logic [63:0] w_data_wdata, w_data_rdata;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u_dut (
    .clk(clk), .resetn(resetn), .mem_en(mem_en), .op(op), .addr(addr), .wdata(wdata),
    .flush(flush), .stall_i(stall_i), .stall_o(stall_o), .rdata_o(rdata_o),
    .done_o(done_o), .adel(adel), .ades(ades), .badvaddr(badvaddr),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .resetn(resetn), .mem_en(w_mem_en), .op(w_op), .addr(w_addr),
    .wdata(w_wdata), .flush(w_flush), .stall_i(w_stall_i), .stall_o(w_stall_o),
    .rdata_o(w_rdata_o), .done_o(w_done), .adel(w_adel), .ades(w_ades),
    .badvaddr(w_badvaddr), .data_req(w_data_req), .data_wr(w_data_wr),
    .data_size(w_data_size), .data_addr(w_data_addr), .data_wstrb(w_data_wstrb),
    .data_wdata(w_data_wdata), .data_addr_ok(w_addr_ok), .data_rdata(w_data_rdata),
    .data_data_ok(w_data_ok)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        wr;
  } tb_req_t;
  typedef struct {
    logic        is_load;
    logic [31:0] data;
  } tb_res_t;
  typedef struct {
    logic        adel;
    logic        ades;
    logic [31:0] bad;
  } tb_exc_t;

  tb_req_t     exp_req_q[$];
  tb_res_t     exp_res_q[$];
  tb_exc_t     exp_exc_q[$];
  logic [31:0] rsp_q[$];

  // Reference: access width in bytes decides alignment, strobe, replication and extension.
  function automatic void expect_tx(input logic [5:0] o, input logic [31:0] a, wd, rd,
                                    input int mode);
    int      bytes;
    bit      mem, load, sgn, fault;
    int      off;
    logic [31:0] v, res;
    tb_req_t r;
    mem = 1; load = 0; sgn = 0; bytes = 4;
    case (o)
      OP_LB:   begin bytes = 1; load = 1; sgn = 1; end
      OP_LBU:  begin bytes = 1; load = 1; end
      OP_LH:   begin bytes = 2; load = 1; sgn = 1; end
      OP_LHU:  begin bytes = 2; load = 1; end
      OP_LW:   begin bytes = 4; load = 1; end
      OP_SB:   bytes = 1;
      OP_SH:   bytes = 2;
      OP_SW:   bytes = 4;
      default: mem = 0;
    endcase
    if (!mem) return;
    off   = int'(a % 4);
    fault = (a % bytes) != 0;
    if (fault) begin
      exp_exc_q.push_back('{load, !load, a});
      return;
    end
    if (mode == 4) return;
    r.addr  = a;
    r.size  = (bytes == 1) ? 2'd0 : (bytes == 2) ? 2'd1 : 2'd2;
    r.wr    = !load;
    r.wstrb = load ? 4'h0 : 4'(((1 << bytes) - 1) << off);
    r.wdata = (bytes == 1) ? wd[7:0] * 32'h01010101 :
              (bytes == 2) ? wd[15:0] * 32'h00010001 : wd;
    exp_req_q.push_back(r);
    rsp_q.push_back(rd);
    v = rd >> (8 * off);
    if (bytes == 1) begin
      res = v & 32'hFF;
      if (sgn && res[7]) res = res | 32'hFFFFFF00;
    end else if (bytes == 2) begin
      res = v & 32'hFFFF;
      if (sgn && res[15]) res = res | 32'hFFFF0000;
    end else begin
      res = v;
    end
    if (mode == 0 || mode == 3) exp_res_q.push_back('{load, res});
  endfunction

  // Called at posedge+1 after an issue; flush modes: 1 in REQ, 2 in WAIT, 3 in DONE.
  task automatic wait_idle(input int mode);
    bit seen_req = 0;
    bit fl_done = 0;
    for (int c = 0; c < 80; c++) begin
      flush = 1'b0;
      if (!stall_o && !done_o) return;
      if (data_req) seen_req = 1;
      if (!fl_done && ((mode == 1 && data_req) ||
                       (mode == 2 && seen_req && !data_req && stall_o) ||
                       (mode == 3 && done_o))) begin
        flush   = 1'b1;
        fl_done = 1;
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
    check("idle_timeout", {62'd0, stall_o, done_o}, 64'd0);
  endtask

  task automatic issue(input logic [5:0] o, input logic [31:0] a, wd, rd, input int mode);
    expect_tx(o, a, wd, rd, mode);
    mem_en = 1'b1; op = o; addr = a; wdata = wd; flush = (mode == 4);
    if (mode == 4) begin
      @(negedge clk);
      check("flush_idle_no_stall", stall_o, 0);
    end
    @(posedge clk); #1;
    mem_en = 1'b0; flush = 1'b0;
    wait_idle(mode);
  endtask

  // Bus responder for the 32-bit instance.
  bit fast = 0, hold = 0, rand_stall = 0;
  int ph = 0, cnt = 0;
  initial begin
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    forever begin
      @(posedge clk); #1;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
      if (!resetn) begin
        ph = 0;
      end else begin
        if (ph == 0 && data_req) begin
          ph = 1; cnt = fast ? 0 : $urandom_range(0, 2);
        end
        if (ph == 1) begin
          if (!hold) begin
            if (cnt == 0) begin
              data_addr_ok = 1'b1; ph = 2; cnt = fast ? 0 : $urandom_range(0, 2);
            end else cnt--;
          end
        end else if (ph == 2) begin
          if (cnt == 0) begin
            data_data_ok = 1'b1; ph = 0;
            if (rsp_q.size() > 0) data_rdata = rsp_q.pop_front();
          end else cnt--;
        end
      end
    end
  end

  initial begin
    stall_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      stall_i = rand_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a request, result or exception.
  bit done_prev = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        done_prev = 0;
      end else begin
        if (data_req && data_addr_ok) begin
          if (exp_req_q.size() == 0) check("req_unexpected", data_req, 0);
          else begin
            tb_req_t r;
            r = exp_req_q.pop_front();
            check("req_addr", data_addr, r.addr);
            check("req_size", data_size, r.size);
            check("req_wr", data_wr, r.wr);
            check("req_wstrb", data_wstrb, r.wstrb);
            if (r.wr) check("req_wdata", data_wdata, r.wdata);
          end
        end
        if (done_o && !done_prev) begin
          if (exp_res_q.size() == 0) check("done_unexpected", done_o, 0);
          else begin
            tb_res_t s;
            s = exp_res_q.pop_front();
            if (s.is_load) check("load_rdata", rdata_o, s.data);
          end
        end
        if (adel || ades) begin
          if (exp_exc_q.size() == 0) check("exc_unexpected", {adel, ades}, 0);
          else begin
            tb_exc_t e;
            e = exp_exc_q.pop_front();
            check("exc_adel", adel, e.adel);
            check("exc_ades", ades, e.ades);
            check("exc_badvaddr", badvaddr, e.bad);
            check("exc_no_stall", stall_o, 0);
          end
        end
        done_prev = done_o;
      end
    end
  end

  task automatic tx64(input logic [5:0] o, input logic [31:0] a, wd, input logic [63:0] rd,
                      input logic [7:0] e_strb, input logic [63:0] e_wd, input logic [31:0] e_res,
                      input bit is_store);
    w_mem_en = 1'b1; w_op = o; w_addr = a; w_wdata = wd;
    @(posedge clk); #1;
    w_mem_en = 1'b0;
    @(negedge clk);
    check("w64_req", w_data_req, 1);
    check("w64_wstrb", w_data_wstrb, e_strb);
    if (is_store) check("w64_wdata", w_data_wdata, e_wd);
    @(posedge clk); #1;
    w_addr_ok = 1'b1;
    @(posedge clk); #1;
    w_addr_ok = 1'b0; w_data_ok = 1'b1; w_data_rdata = rd;
    @(posedge clk); #1;
    w_data_ok = 1'b0; w_data_rdata = '0;
    @(negedge clk);
    check("w64_done", w_done, 1);
    if (!is_store) check("w64_rdata", w_rdata_o, e_res);
    @(posedge clk); #1;
  endtask

  logic [5:0] op_tab [9];

  initial begin
    op_tab = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 6'b000000};
    mem_en = 0; op = 0; addr = 0; wdata = 0; flush = 0;
    w_mem_en = 0; w_op = 0; w_addr = 0; w_wdata = 0; w_flush = 0; w_stall_i = 0;
    w_addr_ok = 0; w_data_ok = 0; w_data_rdata = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_req", data_req, 0);
    check("rst_stall", stall_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_wstrb", data_wstrb, 0);
    check("rst_addr", data_addr, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Minimum-latency load.
    fast = 1;
    expect_tx(OP_LW, 32'h1000, 32'h0, 32'hDEADBEEF, 0);
    mem_en = 1'b1; op = OP_LW; addr = 32'h1000; wdata = 0;
    @(negedge clk);
    check("lat_c0_stall", stall_o, 1);
    @(posedge clk); #1;
    mem_en = 1'b0;
    @(negedge clk);
    check("lat_c1_req", data_req, 1);
    check("lat_c1_stall", stall_o, 1);
    @(negedge clk);
    check("lat_c2_stall", stall_o, 1);
    check("lat_c2_done", done_o, 0);
    @(negedge clk);
    check("lat_c3_done", done_o, 1);
    check("lat_c3_stall", stall_o, 0);
    check("lat_c3_rdata", rdata_o, 32'hDEADBEEF);
    @(posedge clk); #1;
    wait_idle(0);
    fast = 0;

    issue(OP_LB, 32'h1003, 32'h0, 32'h80112233, 0);
    issue(OP_LBU, 32'h1003, 32'h0, 32'h80112233, 0);
    issue(OP_SH, 32'h2002, 32'h0000ABCD, $urandom, 0);
    issue(OP_LW, 32'h1002, 32'h0, $urandom, 0);
    issue(OP_SW, 32'h1001, 32'h12345678, $urandom, 0);
    issue(OP_LW, 32'h1000, 32'h0, $urandom, 2);
    issue(OP_LH, 32'h1006, 32'h0, $urandom, 1);
    issue(OP_LHU, 32'h1002, 32'h0, 32'hF00D0000, 3);
    issue(OP_LW, 32'h1000, 32'h0, $urandom, 4);

    rand_stall = 1;
    for (int i = 0; i < 250; i++) begin
      logic [5:0]  o;
      logic [31:0] a;
      int          md;
      o  = op_tab[$urandom_range(0, 8)];
      a  = $urandom;
      md = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      issue(o, a, $urandom, $urandom, md);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_stall = 0;
    repeat (4) @(posedge clk);
    #1;
    check("req_q_empty", exp_req_q.size(), 0);
    check("res_q_empty", exp_res_q.size(), 0);
    check("exc_q_empty", exp_exc_q.size(), 0);

    // Asynchronous reset while a request is outstanding.
    hold = 1;
    mem_en = 1'b1; op = OP_LW; addr = 32'h40;
    @(posedge clk); #1;
    mem_en = 1'b0;
    @(negedge clk);
    check("rst_mid_req_before", data_req, 1);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_req_after", data_req, 0);
    check("rst_mid_stall", stall_o, 0);
    @(posedge clk); #1;
    resetn = 1'b1; hold = 0;
    @(posedge clk); #1;

    tx64(OP_SB, 32'h3005, 32'h7F, 64'h0, 8'h20, 64'h7F7F7F7F7F7F7F7F, 32'h0, 1);
    tx64(OP_SW, 32'h3004, 32'hCAFEF00D, 64'h0, 8'hF0, 64'hCAFEF00DCAFEF00D, 32'h0, 1);
    tx64(OP_LW, 32'h3004, 32'h0, 64'h1122334455667788, 8'h00, 64'h0, 32'h11223344, 0);
    tx64(OP_LH, 32'h300A, 32'h0, 64'h8899AABBCCDDEEFF, 8'h00, 64'h0, 32'hFFFFCCDD, 0);
    tx64(OP_LHU, 32'h300E, 32'h0, 64'h8899AABBCCDDEEFF, 8'h00, 64'h0, 32'h00008899, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
